baccarat_round_fsm: RTL

Round controller for the baccarat datapath: a Moore state machine clocked by the slow (push-button) clock. It sequences the bet capture, the four initial card loads, the player and banker third-card decisions and balance settlement, using the player/dealer scores and player third card fed back from the datapath. It drives the datapath's load, bet and balance enables, and the win lights.

---
 rtl/baccarat_pkg.sv | 41 ++++
 rtl/banker_draw.sv | 32 +++
 rtl/baccarat_round_fsm.sv | 118 +++++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// ---------------------------------------------------------------------------
// baccarat_pkg : shared states, rank constants and card-value helper.
// Macro: BACCARAT_BETTING_EN adds the BET and SETTLE states.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package baccarat_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
`ifdef BACCARAT_BETTING_EN
    ST_BET    = 4'd1,
    ST_SETTLE = 4'd10,
`endif
    ST_P1     = 4'd2,
    ST_D1     = 4'd3,
    ST_P2     = 4'd4,
    ST_D2     = 4'd5,
    ST_EVAL_P = 4'd6,
    ST_P3     = 4'd7,
    ST_EVAL_D = 4'd8,
    ST_D3     = 4'd9,
    ST_DONE   = 4'd11
  } state_t;

  localparam logic [3:0] RANK_EMPTY       = 4'd0;
  localparam logic [3:0] RANK_TEN         = 4'd10;
  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

  // Ten, face cards and the unused codes 14-15 all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank == RANK_EMPTY || rank >= RANK_TEN)
      return 4'd0;
    else
      return rank;
  endfunction

endpackage

`default_nettype wire

// File: rtl/banker_draw.sv
// ---------------------------------------------------------------------------
// banker_draw : banker third-card rule from banker score and player card 3.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module banker_draw
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/baccarat_round_fsm.sv
// ---------------------------------------------------------------------------
// baccarat_round_fsm : Moore round controller for the baccarat datapath.
// Macro: BACCARAT_BETTING_EN enables bet capture and settlement.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module baccarat_round_fsm
  import baccarat_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       betenabled,
  output logic       updatebalanceenable,
  output logic       player_win_light,
  output logic       dealer_win_light
);

`ifdef BACCARAT_BETTING_EN
  localparam state_t FIRST_STATE = ST_BET;
  localparam state_t CLOSE_STATE = ST_SETTLE;
`else
  localparam state_t FIRST_STATE = ST_P1;
  localparam state_t CLOSE_STATE = ST_DONE;
`endif

  state_t state;
  state_t next_state;
  logic   banker_draws;
  logic   natural;

  banker_draw u_banker_draw (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draws)
  );

  assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   next_state = FIRST_STATE;
`ifdef BACCARAT_BETTING_EN
      ST_BET:    next_state = ST_P1;
      ST_SETTLE: next_state = ST_DONE;
`endif
      ST_P1:     next_state = ST_D1;
      ST_D1:     next_state = ST_P2;
      ST_P2:     next_state = ST_D2;
      ST_D2:     next_state = ST_EVAL_P;
      ST_EVAL_P: begin
        if (natural)
          next_state = CLOSE_STATE;
        else if (pscore < PLAYER_STAND_MIN)
          next_state = ST_P3;
        else if (dscore < PLAYER_STAND_MIN)
          next_state = ST_D3;
        else
          next_state = CLOSE_STATE;
      end
      ST_P3:     next_state = ST_EVAL_D;
      ST_EVAL_D: next_state = banker_draws ? ST_D3 : CLOSE_STATE;
      ST_D3:     next_state = CLOSE_STATE;
      ST_DONE:   next_state = ST_DONE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the incoming state so they line up with it.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state               <= ST_IDLE;
      load_pcard1         <= 1'b0;
      load_pcard2         <= 1'b0;
      load_pcard3         <= 1'b0;
      load_dcard1         <= 1'b0;
      load_dcard2         <= 1'b0;
      load_dcard3         <= 1'b0;
      player_win_light    <= 1'b0;
      dealer_win_light    <= 1'b0;
`ifdef BACCARAT_BETTING_EN
      betenabled          <= 1'b0;
      updatebalanceenable <= 1'b0;
`endif
    end else begin
      state               <= next_state;
      load_pcard1         <= (next_state == ST_P1);
      load_pcard2         <= (next_state == ST_P2);
      load_pcard3         <= (next_state == ST_P3);
      load_dcard1         <= (next_state == ST_D1);
      load_dcard2         <= (next_state == ST_D2);
      load_dcard3         <= (next_state == ST_D3);
      player_win_light    <= (next_state == ST_DONE) && (pscore >= dscore);
      dealer_win_light    <= (next_state == ST_DONE) && (pscore <= dscore);
`ifdef BACCARAT_BETTING_EN
      betenabled          <= (next_state == ST_BET);
      updatebalanceenable <= (next_state == ST_SETTLE);
`endif
    end
  end

`ifndef BACCARAT_BETTING_EN
  assign betenabled          = 1'b0;
  assign updatebalanceenable = 1'b0;
`endif

endmodule

`default_nettype wire
